uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Parameterised UART transmitter: start bit, LSB-first payload, optional parity, stop bit.
// Every bit is held for max(prescale,1) clk cycles; back-to-back frames need no idle gap.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  // state  | meaning
  // IDLE   | line high, waiting for data_valid
  // START  | driving the start bit (0)
  // DATA   | shifting payload out LSB first
  // PARITY | driving the latched parity bit
  // STOP   | driving the stop bit (1); a new frame may be accepted on its last cycle
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [5:0]            cnt;
  logic [5:0]            p_q;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_bit;

  logic       last;
  logic       accept;
  logic [5:0] p_eff;

  always_comb begin
    p_eff  = (prescale == 6'd0) ? 6'd1 : prescale;
    last   = (cnt == p_q - 6'd1);
    accept = data_valid && ((state == IDLE) || ((state == STOP) && last));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      p_q      <= 6'd1;
      idx      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else if (accept) begin
      state    <= START;
      data_q   <= p_data;
      par_en_q <= par_en;
      par_bit  <= (^p_data) ^ par_typ;
      p_q      <= p_eff;
      cnt      <= '0;
      idx      <= '0;
      tx_out   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        START: begin
          if (last) begin
            state  <= DATA;
            cnt    <= '0;
            tx_out <= data_q[0];
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              // shift so the next payload bit is always at data_q[1]
              idx    <= idx + IDX_W'(1);
              data_q <= data_q >> 1;
              tx_out <= data_q[1];
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        PARITY: begin
          if (last) begin
            state  <= STOP;
            cnt    <= '0;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        STOP: begin
          if (last) begin
            state  <= IDLE;
            cnt    <= '0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
